uart_tx_fifo_wb: RTL and testbench

Wishbone slave peripheral that buffers bytes written by the core's data port in a FIFO and serialises them onto a UART TX line (8N1, LSB first).
It sits on the data-side slave fan-out alongside the timer, UART and loader slaves, occupying the next free window (0x8018-0x801F).
It frees the core from polling a single-byte transmitter and raises a level interrupt when all queued data has been sent.

---
 rtl/uart_tx_fifo_wb_pkg.sv | 39 +++
 rtl/uart_tx_fifo_wb_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo_wb.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_fifo_wb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_wb_pkg.sv
// Shared definitions for the buffered UART transmitter: register offsets,
// STATUS bit layout, transmitter states and the STATUS word packer.
package uart_tx_fifo_wb_pkg;

  localparam logic [2:0] REG_DATA_OFS   = 3'h0;
  localparam logic [2:0] REG_STATUS_OFS = 3'h4;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 16;
  localparam int ST_COUNT_W   = 9;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic                  full,
    input logic                  empty,
    input logic                  busy,
    input logic                  ovf,
    input logic [ST_COUNT_W-1:0] count
  );
    logic [31:0] w;
    w = '0;
    w[ST_FULL_BIT]                     = full;
    w[ST_EMPTY_BIT]                    = empty;
    w[ST_BUSY_BIT]                     = busy;
    w[ST_OVF_BIT]                      = ovf;
    w[ST_COUNT_LSB +: ST_COUNT_W]      = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_wb_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data. A push into a
// full FIFO is only taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_wb.sv
// Wishbone slave that queues bytes in a FIFO and shifts them out as 8N1
// frames, LSB first, with an interrupt when everything has been sent.
module uart_tx_fifo_wb
  import uart_tx_fifo_wb_pkg::*;
#(
  parameter int          SYS_CLK_FREQ = 80000000,
  parameter int          BAUD         = 9600,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADR     = 32'h0000_8018
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_err_o,
  output logic        tx_o,
  output logic        tx_irq_o
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // Bus side
  logic        req, is_data, is_status, wr_data_req, wr_ovf_clr, push_ok;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        ovf_q, ovf_d;

  // FIFO side
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count, cnt_next;

  // Transmitter side
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i[31:8],
                         wb_sel_i[3:1], BASE_ADR};

  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign tx_o       = tx_q;
  assign tx_irq_o   = irq_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push_ok),
    .pop     (fifo_pop),
    .wdata   (wb_dat_i[7:0]),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Only address bit 2 selects the register; the interconnect has already
  // matched the window, so offsets are taken relative to BASE_ADR.
  always_comb begin
    req         = wb_cyc_i & wb_stb_i;
    is_data     = ((wb_adr_i[2] ^ BASE_ADR[2]) == REG_DATA_OFS[2]);
    is_status   = ((wb_adr_i[2] ^ BASE_ADR[2]) == REG_STATUS_OFS[2]);
    wr_data_req = req & wb_we_i & is_data & wb_sel_i[0];
    wr_ovf_clr  = req & wb_we_i & is_status & wb_sel_i[0] & wb_dat_i[ST_OVF_BIT];
    push_ok     = wr_data_req & (~fifo_full | fifo_pop);

    ovf_d = ovf_q;
    if (wr_ovf_clr)               ovf_d = 1'b0;
    if (wr_data_req && !push_ok)  ovf_d = 1'b1;

    ack_d = req;
    err_d = wr_data_req & ~push_ok;
    dat_d = '0;
    if (req && !wb_we_i && is_status) begin
      dat_d = pack_status(fifo_full, fifo_empty, (state_q != TX_IDLE), ovf_q,
                          ST_COUNT_W'(fifo_count));
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = TX_START;
          baud_d   = '0;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = TX_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // The interrupt is built from the post-edge occupancy and state so it
  // falls together with the ack of the first accepted push.
  always_comb begin
    case ({push_ok, fifo_pop})
      2'b10:   cnt_next = fifo_count + CW'(1);
      2'b01:   cnt_next = fifo_count - CW'(1);
      default: cnt_next = fifo_count;
    endcase
    irq_d = (cnt_next == '0) && (state_d == TX_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_wb.sv
// Directed and randomized bench for uart_tx_fifo_wb against a timeline model
// of byte acceptance, frame start times and line levels.
module tb_uart_tx_fifo_wb;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = 32'h0000_8018;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o, wb_ack_o, wb_err_o, tx_o, tx_irq_o;
  logic [31:0] wb_dat_o;

  uart_tx_fifo_wb #(
    .SYS_CLK_FREQ (40),
    .BAUD         (10),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADR     (BASE)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_stall_o (wb_stall_o),
    .wb_ack_o   (wb_ack_o),
    .wb_dat_o   (wb_dat_o),
    .wb_err_o   (wb_err_o),
    .tx_o       (tx_o),
    .tx_irq_o   (tx_irq_o)
  );

  // Clock and edge counter: at a negedge, cyc is the number of rising edges so far.
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Model: each accepted byte has an accept edge and a pop (frame start) edge.
  int          acc_e[$];
  int          pop_e[$];
  logic [7:0]  exp_q[$];
  bit          ovf_m;

  function automatic void model_reset();
    acc_e.delete();
    pop_e.delete();
    exp_q.delete();
    ovf_m = 1'b0;
  endfunction

  function automatic int cnt_after(input int t);
    int n = 0;
    foreach (acc_e[i]) if (acc_e[i] <= t) n++;
    foreach (pop_e[i]) if (pop_e[i] <= t) n--;
    return n;
  endfunction

  function automatic bit pop_at(input int t);
    foreach (pop_e[i]) if (pop_e[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy_after(input int t);
    foreach (pop_e[i]) if (pop_e[i] <= t && t < pop_e[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit tx_after(input int t);
    int idx;
    logic [7:0] b;
    foreach (pop_e[i]) begin
      if (pop_e[i] <= t && t < pop_e[i] + FRAME) begin
        idx = (t - pop_e[i]) / CPB;
        b   = exp_q[i];
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit irq_after(input int t);
    return (cnt_after(t) == 0) && !busy_after(t);
  endfunction

  // Line and interrupt are compared against the model on every falling edge.
  always @(negedge clk_i) begin
    chk("tx_o", {31'b0, tx_o}, {31'b0, tx_after(cyc)});
    chk("tx_irq_o", {31'b0, tx_irq_o}, {31'b0, irq_after(cyc)});
    chk("stall", {31'b0, wb_stall_o}, 32'h0);
  end

  // Driver: called at a negedge, presents one access, returns at the next
  // negedge after checking the ack and response against the model.
  task automatic do_access(input bit we, input bit status, input logic [31:0] dat,
                           input logic [3:0] sel, input string tag);
    int t, c, p;
    logic [31:0] exp_rd;
    bit exp_err;
    t = cyc + 1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = BASE + (status ? 32'd4 : 32'd0);
    wb_dat_i = dat;
    wb_sel_i = sel;
    exp_rd  = '0;
    exp_err = 1'b0;
    if (!we && status) begin
      c = cnt_after(t - 1);
      exp_rd = {7'b0, 9'(c), 12'b0, ovf_m, busy_after(t - 1), (c == 0), (c == DEPTH)};
    end
    if (we && !status && sel[0]) begin
      c = cnt_after(t - 1);
      if (c < DEPTH || pop_at(t)) begin
        acc_e.push_back(t);
        exp_q.push_back(dat[7:0]);
        p = t + 1;
        if (pop_e.size() > 0 && pop_e[$] + FRAME + 1 > p) p = pop_e[$] + FRAME + 1;
        pop_e.push_back(p);
      end else begin
        exp_err = 1'b1;
        ovf_m   = 1'b1;
      end
    end
    if (we && status && sel[0] && dat[3]) ovf_m = 1'b0;
    @(negedge clk_i);
    chk({tag, "_ack"}, {31'b0, wb_ack_o}, 32'h1);
    chk({tag, "_err"}, {31'b0, wb_err_o}, {31'b0, exp_err});
    if (!we) chk({tag, "_rdata"}, wb_dat_o, exp_rd);
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'h0;
    @(negedge clk_i);
    chk("idle_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("idle_err", {31'b0, wb_err_o}, 32'h0);
    chk("idle_dat", wb_dat_o, 32'h0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [7:0]  b;
    logic [3:0]  sel;
    int          p_next, guard, target, op, gap;

    // Clock/reset
    model_reset();
    reset_i  = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = BASE;
    wb_dat_i = '0;
    wb_sel_i = 4'h0;
    wait_cycles(3);
    chk("rst_tx", {31'b0, tx_o}, 32'h1);
    chk("rst_irq", {31'b0, tx_irq_o}, 32'h1);
    chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    reset_i = 1'b1;
    wait_cycles(1);

    // 1: STATUS after reset
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "t1_status");
    chk("t1_const", wb_dat_o, 32'h0000_0002);
    bus_idle();

    // 2: single byte 0xA5, line pattern held CPB clocks per bit
    do_access(1'b1, 1'b0, 32'h0000_00A5, 4'b0001, "t2_wr");
    bus_idle();
    pat = 10'b1101001010;
    for (int i = 0; i < FRAME; i++) begin
      chk("t2_line", {31'b0, tx_o}, {31'b0, pat[i / CPB]});
      @(negedge clk_i);
    end
    chk("t2_irq_back", {31'b0, tx_irq_o}, 32'h1);
    wait_cycles(3);

    // 3: three back-to-back bytes, STATUS shows two queued and busy
    do_access(1'b1, 1'b0, 32'h11, 4'b0001, "t3_wr0");
    do_access(1'b1, 1'b0, 32'h22, 4'b0001, "t3_wr1");
    do_access(1'b1, 1'b0, 32'h33, 4'b0001, "t3_wr2");
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "t3_status");
    chk("t3_count", {23'b0, wb_dat_o[24:16]}, 32'd2);
    chk("t3_busy", {31'b0, wb_dat_o[2]}, 32'h1);
    bus_idle();
    wait_cycles(3 * (FRAME + 1) + 5);

    // 4: overflow while busy, then clear it
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255)) & 8'hFB;
      do_access(1'b1, 1'b0, {24'h0, b}, 4'b0001, "t4_wr");
    end
    chk("t4_err6", {31'b0, wb_err_o}, 32'h1);
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "t4_st_ovf");
    chk("t4_ovf_set", {31'b0, wb_dat_o[3]}, 32'h1);
    do_access(1'b1, 1'b1, 32'h8, 4'b0001, "t4_clr");
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "t4_st_clr");
    chk("t4_ovf_clr", {31'b0, wb_dat_o[3]}, 32'h0);
    bus_idle();

    // 5: asynchronous reset in clock 15 of a frame
    p_next = -1;
    foreach (pop_e[i]) if (p_next < 0 && pop_e[i] > cyc) p_next = pop_e[i];
    chk("t5_have_frame", {31'b0, (p_next >= 0)}, 32'h1);
    guard = 0;
    while (p_next >= 0 && cyc < p_next + 14 && guard < 500) begin
      @(negedge clk_i);
      guard++;
    end
    chk("t5_line_low", {31'b0, tx_o}, 32'h0);
    #2;
    reset_i = 1'b0;
    model_reset();
    #1;
    chk("t5_tx_async", {31'b0, tx_o}, 32'h1);
    chk("t5_irq_async", {31'b0, tx_irq_o}, 32'h1);
    wait_cycles(3);
    reset_i = 1'b1;
    wait_cycles(1);
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "t5_status");
    chk("t5_const", wb_dat_o, 32'h0000_0002);
    bus_idle();
    wait_cycles(2 * FRAME);

    // 6: DATA write without sel[0] is a no-op
    do_access(1'b1, 1'b0, 32'h5A, 4'b0010, "t6_wr");
    chk("t6_err", {31'b0, wb_err_o}, 32'h0);
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "t6_status");
    chk("t6_const", wb_dat_o, 32'h0000_0002);
    do_access(1'b0, 1'b0, 32'h0, 4'hF, "t6_data_rd");
    bus_idle();
    wait_cycles(FRAME);

    // Randomized mix of accesses with random gaps
    for (int n = 0; n < 80; n++) begin
      op  = $urandom_range(0, 9);
      sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) sel[0] = 1'b1;
      if (op <= 5)      do_access(1'b1, 1'b0, $urandom, sel, "rnd_wr");
      else if (op <= 7) do_access(1'b0, 1'b1, 32'h0, sel, "rnd_st");
      else if (op == 8) do_access(1'b1, 1'b1, $urandom, sel, "rnd_stw");
      else              do_access(1'b0, 1'b0, 32'h0, sel, "rnd_rd");
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        bus_idle();
        wait_cycles(gap - 1);
      end
      if ($urandom_range(0, 7) == 0) begin
        bus_idle();
        wait_cycles(FRAME);
      end
    end
    bus_idle();

    // Drain everything queued, with a bounded wait
    target = (pop_e.size() > 0) ? pop_e[$] + FRAME + 3 : cyc;
    guard  = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge clk_i);
      guard++;
    end
    chk("drain_timeout", {31'b0, (cyc >= target)}, 32'h1);
    do_access(1'b0, 1'b1, 32'h0, 4'hF, "end_status");
    chk("end_empty", {31'b0, wb_dat_o[1]}, 32'h1);
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
